usage_window_sampler: RTL and testbench

- Drives the MCU utilization measurement path from both sides of the busy counter.
- Generates the periodic sample_enable strobe that the busy counter consumes.
- Every WINDOW_SAMPLES strobes, it captures the counter's value into an MCU-readable result register and pulses the counter clear.
- Tracks the peak window result and flags unacknowledged results (overrun), so firmware reads a stable per-window utilization figure instead of a free-running count.

---
 rtl/usage_window_sampler.sv | 147 ++++++++++++++
 tb/tb_usage_window_sampler.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/usage_window_sampler.sv
// usage_window_sampler
//   Sequences the MCU utilization measurement around an external busy counter.
//   A prescaler produces a sample strobe every SAMPLE_DIV cycles while running.
//   After WINDOW_SAMPLES strobes the counter value is captured into a readable
//   result register, the peak is updated and the counter is cleared, so
//   firmware sees one stable figure per window.
//
// Ports
//   sysclk        in   system clock, rising edge
//   sysreset      in   synchronous reset, active low
//   enable        in   run request; 0 stops sampling (partial window dropped)
//   busy_count    in   CNT_W busy count from the busy counter
//   sample_enable out  one-cycle sample strobe to the busy counter
//   counter_reset out  one-cycle registered clear pulse to the busy counter
//   usage_result  out  CNT_W busy count of the last completed window
//   usage_peak    out  CNT_W largest usage_result since reset / peak_clear
//   result_valid  out  sticky, set on capture
//   overrun       out  sticky, set when a capture finds result_valid still set
//   result_ack    in   pulse; clears result_valid and overrun
//   peak_clear    in   pulse; clears usage_peak
//   window_pulse  out  one-cycle pulse during the capture cycle
module usage_window_sampler #(
  parameter int SAMPLE_DIV     = 50,
  parameter int WINDOW_SAMPLES = 1000,
  parameter int CNT_W          = 16
) (
  input  logic             sysclk,
  input  logic             sysreset,
  input  logic             enable,
  input  logic [CNT_W-1:0] busy_count,
  output logic             sample_enable,
  output logic             counter_reset,
  output logic [CNT_W-1:0] usage_result,
  output logic [CNT_W-1:0] usage_peak,
  output logic             result_valid,
  output logic             overrun,
  input  logic             result_ack,
  input  logic             peak_clear,
  output logic             window_pulse
);

  localparam int PRE_W  = $clog2(SAMPLE_DIV);
  localparam int SCNT_W = (WINDOW_SAMPLES > 1) ? $clog2(WINDOW_SAMPLES) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(SAMPLE_DIV - 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(WINDOW_SAMPLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    RUN     = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [PRE_W-1:0]  prescaler;
  logic [SCNT_W-1:0] sample_cnt;
  logic              strobe;
  logic              capture;

  // Unsigned maximum used for the peak tracker.
  function automatic logic [CNT_W-1:0] max_u(input logic [CNT_W-1:0] a,
                                             input logic [CNT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // State register
  always_ff @(posedge sysclk) begin
    if (!sysreset) state <= IDLE;
    else           state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (enable) state_next = CLEAR;
      CLEAR:   state_next = enable ? RUN : IDLE;
      RUN: begin
        // Dropping enable wins over a completing window: partial data is discarded.
        if (!enable)                              state_next = CLEAR;
        else if (strobe && sample_cnt == SCNT_LAST) state_next = CAPTURE;
      end
      CAPTURE: state_next = CLEAR;
      default: state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    strobe  = 1'b0;
    capture = 1'b0;
    if (state == RUN && prescaler == PRE_LAST) strobe = 1'b1;
    if (state == CAPTURE)                      capture = 1'b1;
  end

  assign sample_enable = strobe;

  // Prescaler and strobe counter; CLEAR always lasts one cycle, so zeroing
  // them there starts every window from a known phase.
  always_ff @(posedge sysclk) begin
    if (!sysreset) begin
      prescaler  <= '0;
      sample_cnt <= '0;
    end else if (state == CLEAR) begin
      prescaler  <= '0;
      sample_cnt <= '0;
    end else if (state == RUN) begin
      if (strobe) begin
        prescaler  <= '0;
        sample_cnt <= sample_cnt + 1'b1;
      end else begin
        prescaler  <= prescaler + 1'b1;
      end
    end
  end

  // Registered pulses and result registers
  always_ff @(posedge sysclk) begin
    if (!sysreset) begin
      counter_reset <= 1'b0;
      window_pulse  <= 1'b0;
      usage_result  <= '0;
      usage_peak    <= '0;
      result_valid  <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      counter_reset <= (state_next == CLEAR);
      window_pulse  <= (state_next == CAPTURE);
      if (capture) begin
        // busy_count already includes the final strobe of the window.
        usage_result <= busy_count;
        usage_peak   <= peak_clear ? busy_count : max_u(usage_peak, busy_count);
        result_valid <= 1'b1;
        // An ack in the capture cycle consumes the previous result.
        overrun      <= result_ack ? 1'b0 : (overrun | result_valid);
      end else begin
        if (result_ack) begin
          result_valid <= 1'b0;
          overrun      <= 1'b0;
        end
        if (peak_clear) usage_peak <= '0;
      end
    end
  end

endmodule

// File: tb/tb_usage_window_sampler.sv
module tb_usage_window_sampler;

  localparam int SAMPLE_DIV     = 4;
  localparam int WINDOW_SAMPLES = 8;
  localparam int CNT_W          = 16;

  logic             sysclk = 1'b0;
  logic             sysreset;
  logic             enable;
  logic [CNT_W-1:0] busy_count;
  logic             sample_enable;
  logic             counter_reset;
  logic [CNT_W-1:0] usage_result;
  logic [CNT_W-1:0] usage_peak;
  logic             result_valid;
  logic             overrun;
  logic             result_ack;
  logic             peak_clear;
  logic             window_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  int quota = 8;
  logic [CNT_W-1:0] bc = '0;

  usage_window_sampler #(
    .SAMPLE_DIV    (SAMPLE_DIV),
    .WINDOW_SAMPLES(WINDOW_SAMPLES),
    .CNT_W         (CNT_W)
  ) dut (
    .sysclk       (sysclk),
    .sysreset     (sysreset),
    .enable       (enable),
    .busy_count   (busy_count),
    .sample_enable(sample_enable),
    .counter_reset(counter_reset),
    .usage_result (usage_result),
    .usage_peak   (usage_peak),
    .result_valid (result_valid),
    .overrun      (overrun),
    .result_ack   (result_ack),
    .peak_clear   (peak_clear),
    .window_pulse (window_pulse)
  );

  always #5 sysclk = ~sysclk;

  // Busy counter model: the monitored block is busy for the first `quota`
  // samples of each window.
  always @(posedge sysclk) begin
    if (counter_reset)                            bc <= '0;
    else if (sample_enable && (int'(bc) < quota)) bc <= bc + 16'd1;
  end
  assign busy_count = bc;

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return sample_enable;
      1:       return window_pulse;
      default: return counter_reset;
    endcase
  endfunction

  // Advance at least one cycle, then until the selected signal is high.
  task automatic wait_for(input string tag, input int sel, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!sig(sel) && cyc < 200);
    chk({tag, "_seen"}, 32'(sig(sel)), 1);
  endtask

  initial begin
    int cyc;
    int n;
    sysreset   = 1'b0;
    enable     = 1'b1;
    result_ack = 1'b0;
    peak_clear = 1'b0;
    quota      = 8;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_flags", {27'd0, sample_enable, counter_reset, window_pulse, result_valid, overrun}, 0);
      chk("rst_result", 32'(usage_result), 0);
      chk("rst_peak", 32'(usage_peak), 0);
    end
    sysreset = 1'b1;

    // Window 1: always busy
    wait_for("w1_clear", 2, cyc);
    chk("w1_clear_lat", cyc, 1);
    tick();
    chk("w1_clear_one_cycle", 32'(counter_reset), 0);
    wait_for("w1_strobe", 0, cyc);
    chk("w1_first_strobe", cyc, 3);
    for (int i = 1; i < 8; i++) begin
      wait_for("w1_strobe", 0, cyc);
      chk("w1_strobe_spacing", cyc, 4);
    end
    wait_for("w1_wp", 1, cyc);
    chk("w1_capture_lat", cyc, 1);
    chk("w1_no_strobe_in_capture", 32'(sample_enable), 0);
    wait_for("w1_clr2", 2, cyc);
    chk("w1_clear_after_capture", cyc, 1);
    chk("w1_result", 32'(usage_result), 8);
    chk("w1_peak", 32'(usage_peak), 8);
    chk("w1_valid", 32'(result_valid), 1);
    chk("w1_overrun", 32'(overrun), 0);

    // Window 2: 3 busy samples, no ack
    quota = 3;
    wait_for("w2_strobe", 0, cyc);
    chk("w2_first_strobe", cyc, 4);
    wait_for("w2_wp", 1, cyc);
    chk("w2_capture_lat", cyc, 29);
    wait_for("w2_clr", 2, cyc);
    chk("w2_result", 32'(usage_result), 3);
    chk("w2_peak", 32'(usage_peak), 8);
    chk("w2_valid", 32'(result_valid), 1);
    chk("w2_overrun", 32'(overrun), 1);
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    chk("ack_valid", 32'(result_valid), 0);
    chk("ack_overrun", 32'(overrun), 0);

    // Peak clear alone, then window 3 with ack in capture
    quota = 5;
    peak_clear = 1'b1;
    tick();
    peak_clear = 1'b0;
    chk("peak_clear_alone", 32'(usage_peak), 0);
    wait_for("w3_wp", 1, cyc);
    chk("w3_capture_lat", cyc, 31);
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    chk("w3_clear", 32'(counter_reset), 1);
    chk("w3_result", 32'(usage_result), 5);
    chk("w3_peak", 32'(usage_peak), 5);
    chk("w3_valid", 32'(result_valid), 1);
    chk("w3_overrun", 32'(overrun), 0);

    // Window 4: ack and peak_clear both in capture, previous result still valid
    quota = 2;
    wait_for("w4_wp", 1, cyc);
    chk("w4_period", cyc, 33);
    result_ack = 1'b1;
    peak_clear = 1'b1;
    tick();
    result_ack = 1'b0;
    peak_clear = 1'b0;
    chk("w4_result", 32'(usage_result), 2);
    chk("w4_peak", 32'(usage_peak), 2);
    chk("w4_valid", 32'(result_valid), 1);
    chk("w4_overrun", 32'(overrun), 0);

    // Window 5: abort after 5 strobes
    quota = 8;
    for (int i = 0; i < 5; i++) wait_for("w5_strobe", 0, cyc);
    enable = 1'b0;
    tick();
    chk("abort_clear", 32'(counter_reset), 1);
    chk("abort_no_wp", 32'(window_pulse), 0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sample_enable || window_pulse || counter_reset) n++;
    end
    chk("idle_quiet", n, 0);
    chk("abort_result_kept", 32'(usage_result), 2);
    chk("abort_valid_kept", 32'(result_valid), 1);

    enable = 1'b1;
    tick();
    chk("reenable_clear", 32'(counter_reset), 1);
    n = 0;
    cyc = 0;
    do begin
      tick();
      cyc++;
      if (sample_enable) n++;
    end while (!window_pulse && cyc < 200);
    chk("fresh_strobes", n, 8);
    chk("fresh_capture_lat", cyc, 33);
    tick();
    chk("fresh_result", 32'(usage_result), 8);
    chk("fresh_peak", 32'(usage_peak), 8);
    chk("fresh_overrun", 32'(overrun), 1);

    // Reset mid-operation
    sysreset = 1'b0;
    tick();
    chk("rst2_flags", {27'd0, sample_enable, counter_reset, window_pulse, result_valid, overrun}, 0);
    chk("rst2_result", 32'(usage_result), 0);
    chk("rst2_peak", 32'(usage_peak), 0);
    sysreset = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
